// File: rtl/step_segment_seq_if.sv
// step_segment_seq_if: host/generator-facing bundle of the segment sequencer
// master: host + generator side (drives writes, enable, abort, gen_busy)
// slave : sequencer side (drives dt_val/steps_val/load, FIFO status and flags)
// Optional: STEP_SEQ_UNDERRUN_CNT_EN adds underrun_cnt[15:0]
interface step_segment_seq_if #(parameter int ADDR_W = 4);
  logic wr_en;
  logic [31:0] wr_dt;
  logic [31:0] wr_steps;
  logic enable;
  logic abort;
  logic gen_busy;
  logic [31:0] dt_val;
  logic [31:0] steps_val;
  logic load;
  logic [ADDR_W:0] count;
  logic full;
  logic empty;
  logic running;
  logic underrun;
  logic overflow;
`ifdef STEP_SEQ_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif
  modport master (
    output wr_en, wr_dt, wr_steps, enable, abort, gen_busy,
`ifdef STEP_SEQ_UNDERRUN_CNT_EN
    input underrun_cnt,
`endif
    input dt_val, steps_val, load, count, full, empty, running, underrun, overflow
  );
  modport slave (
    input wr_en, wr_dt, wr_steps, enable, abort, gen_busy,
`ifdef STEP_SEQ_UNDERRUN_CNT_EN
    output underrun_cnt,
`endif
    output dt_val, steps_val, load, count, full, empty, running, underrun, overflow
  );
endinterface

// File: rtl/step_segment_seq.sv
// step_segment_seq: segment FIFO and sequencer feeding acc_step_gen one (dt, steps) segment at a time
// Ports: clk (rising edge), reset (async, active-high),
//   bus (step_segment_seq_if.slave): wr_en/wr_dt/wr_steps push, enable, abort, gen_busy in;
//   dt_val/steps_val/load to the generator, count/full/empty/running, sticky underrun/overflow out.
// Optional: define STEP_SEQ_UNDERRUN_CNT_EN for bus.underrun_cnt, a saturating count of underrun events.
module step_segment_seq #(
  parameter int ADDR_W = 4,
  parameter int ACK_TMO = 4
) (
  input logic clk,
  input logic reset,
  step_segment_seq_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW = $clog2(ACK_TMO + 1);
  typedef enum logic [1:0] {IDLE, POP, WAIT_ACK, RUN} state_t;
  state_t state, state_nxt;
  logic [63:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp, rp;
  logic [ADDR_W:0] cnt;
  logic [TW-1:0] tmo;
  logic [31:0] dt_q, steps_q, head_dt, head_steps;
  logic und_q, ovf_q, full, empty, push, pop, load, done, und_set, go;
  always_comb begin
    {head_dt, head_steps} = mem[rp];
    full = cnt == (ADDR_W+1)'(DEPTH);
    empty = cnt == '0;
    pop = state == POP && !empty && !bus.abort;
    // a pop frees a slot, so a write into a full FIFO is accepted in the same cycle
    push = bus.wr_en && (!full || pop) && !bus.abort;
    load = pop && head_steps != '0;
    // a missing busy acknowledge is treated like the generator finishing
    done = !bus.gen_busy && (state == RUN || (state == WAIT_ACK && tmo == TW'(ACK_TMO - 1)));
    und_set = done && bus.enable && empty && !bus.abort;
    go = bus.enable && !empty;
    state_nxt = state;
    if (bus.abort) state_nxt = IDLE;
    else
      case (state)
        IDLE: state_nxt = go && !bus.gen_busy ? POP : IDLE;
        POP: state_nxt = load ? WAIT_ACK : (cnt > (ADDR_W+1)'(1) || push) ? POP : IDLE;
        WAIT_ACK: state_nxt = bus.gen_busy ? RUN : done ? (go ? POP : IDLE) : WAIT_ACK;
        default: state_nxt = done ? (go ? POP : IDLE) : RUN;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      tmo <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      und_q <= 1'b0;
      ovf_q <= 1'b0;
      dt_q <= '0;
      steps_q <= '0;
    end else begin
      state <= state_nxt;
      tmo <= state == WAIT_ACK ? tmo + 1'b1 : '0;
      wp <= bus.abort ? '0 : wp + ADDR_W'(push);
      rp <= bus.abort ? '0 : rp + ADDR_W'(pop);
      cnt <= bus.abort ? '0 : cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      und_q <= !bus.abort && (und_q || und_set);
      ovf_q <= !bus.abort && (ovf_q || (bus.wr_en && full && !pop));
      if (load) begin
        dt_q <= head_dt;
        steps_q <= head_steps;
      end
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= {bus.wr_dt, bus.wr_steps};
`ifdef STEP_SEQ_UNDERRUN_CNT_EN
  logic [15:0] ucnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) ucnt <= '0;
    else if (bus.abort) ucnt <= '0;
    else if (und_set && ucnt != '1) ucnt <= ucnt + 1'b1;
  assign bus.underrun_cnt = ucnt;
`endif
  // the head is shown combinationally during the load cycle so the generator samples it with load
  assign bus.dt_val = load ? head_dt : dt_q;
  assign bus.steps_val = load ? head_steps : steps_q;
  assign bus.load = load;
  assign bus.count = cnt;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.running = state != IDLE;
  assign bus.underrun = und_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_step_segment_seq.sv
// tb_step_segment_seq: self-checking bench for step_segment_seq with a generator model and load log
`timescale 1ns/1ps
module tb_step_segment_seq;
  localparam int ADDR_W = 4;
  localparam int ACK_TMO = 4;
  typedef struct {logic [31:0] dt; logic [31:0] steps; int t;} ld_t;
  typedef struct {logic wr; logic ab; logic [31:0] dt; logic [31:0] st; logic [4:0] cnt; logic full; logic empty; logic ovf;} vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_pass = 0;
  int n_chk = 0;
  int ncyc = 0;
  int gcnt = 0;
  int busy_len = 5;
  logic gen_ack = 1'b1;
  int inv_bad = 0;
  logic prev_load = 1'b0;
  ld_t lq[$];
  always #5 clk = ~clk;
  step_segment_seq_if #(.ADDR_W(ADDR_W)) bus();
  step_segment_seq #(.ADDR_W(ADDR_W), .ACK_TMO(ACK_TMO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always @(posedge clk) ncyc++;
  always @(posedge clk or posedge reset)
    if (reset) gcnt <= 0;
    else if (bus.load && gen_ack) gcnt <= busy_len;
    else if (gcnt > 0) gcnt <= gcnt - 1;
  assign bus.gen_busy = gcnt != 0;
  always @(negedge clk) begin
    if (bus.load) begin
      lq.push_back('{bus.dt_val, bus.steps_val, ncyc});
      if (bus.gen_busy || prev_load) inv_bad++;
    end
    prev_load = bus.load;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.wr_en = 0; bus.wr_dt = 0; bus.wr_steps = 0; bus.enable = 0; bus.abort = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
  endtask
  task automatic push_seg(input logic [31:0] dt, input logic [31:0] st);
    bus.wr_en = 1; bus.wr_dt = dt; bus.wr_steps = st;
    tick();
    bus.wr_en = 0;
  endtask
  task automatic wait_loads(input string nm, input int n, input int bound);
    int i = 0;
    while (lq.size() < n && i < bound) begin tick(); i++; end
    chk(nm, lq.size(), n);
  endtask
  vec_t vt[19];
  int b, t0, i, k, nexp;
  logic [31:0] dt, st;
  logic und_exp, last_nz;
  ld_t exp_q[$];
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    chk("rst_flags", {bus.load, bus.full, bus.running, bus.underrun, bus.overflow, bus.empty}, 6'b000001);
    chk("rst_count", bus.count, 0);
    chk("rst_dt", bus.dt_val, 0);
    chk("rst_steps", bus.steps_val, 0);
    // 1: single segment, 2-cycle latency, hold while busy
    busy_len = 40; gen_ack = 1; bus.enable = 1;
    b = lq.size(); t0 = ncyc;
    push_seg(20, 3);
    chk("t1_no_early_load", bus.load, 0);
    wait_loads("t1_nloads", b + 1, 10);
    if (lq.size() > b) begin
      chk("t1_latency", lq[b].t - t0, 2);
      chk("t1_dt", lq[b].dt, 20);
      chk("t1_steps", lq[b].steps, 3);
    end
    chk("t1_running", bus.running, 1);
    tick();
    chk("t1_busy", bus.gen_busy, 1);
    i = 0;
    while (bus.gen_busy && i < 100) begin tick(); i++; end
    chk("t1_run_at_fall", bus.running, 1);
    tick();
    chk("t1_idle", bus.running, 0);
    chk("t1_underrun", bus.underrun, 1);
    chk("t1_dt_hold", bus.dt_val, 20);
    // 2: three segments back to back
    do_reset();
    busy_len = 5; bus.enable = 1;
    b = lq.size(); t0 = ncyc;
    push_seg(20, 3); push_seg(30, 5); push_seg(10, 1);
    wait_loads("t2_nloads", b + 3, 100);
    if (lq.size() >= b + 3) begin
      chk("t2_lat0", lq[b].t - t0, 2);
      chk("t2_gap1", lq[b+1].t - lq[b].t, busy_len + 2);
      chk("t2_gap2", lq[b+2].t - lq[b+1].t, busy_len + 2);
      chk("t2_seg0", {lq[b].dt[15:0], lq[b].steps[15:0]}, {16'd20, 16'd3});
      chk("t2_seg1", {lq[b+1].dt[15:0], lq[b+1].steps[15:0]}, {16'd30, 16'd5});
      chk("t2_seg2", {lq[b+2].dt[15:0], lq[b+2].steps[15:0]}, {16'd10, 16'd1});
    end
    repeat (10) tick();
    chk("t2_underrun", bus.underrun, 1);
    chk("t2_count", bus.count, 0);
    // 3: table-driven fill past full with enable low, then abort
    do_reset();
    for (int j = 0; j < 17; j++)
      vt[j] = '{1'b1, 1'b0, 32'(100 + j), 32'(j + 1), 5'(j < 16 ? j + 1 : 16), j >= 15, 1'b0, j == 16};
    vt[17] = '{1'b1, 1'b1, 32'd7, 32'd7, 5'd0, 1'b0, 1'b1, 1'b0};
    vt[18] = '{1'b1, 1'b0, 32'd8, 32'd8, 5'd1, 1'b0, 1'b0, 1'b0};
    b = lq.size();
    for (int j = 0; j < 19; j++) begin
      bus.wr_en = vt[j].wr; bus.abort = vt[j].ab; bus.wr_dt = vt[j].dt; bus.wr_steps = vt[j].st;
      tick();
      bus.wr_en = 0; bus.abort = 0;
      chk($sformatf("t3_count_%0d", j), bus.count, vt[j].cnt);
      chk($sformatf("t3_full_%0d", j), bus.full, vt[j].full);
      chk($sformatf("t3_empty_%0d", j), bus.empty, vt[j].empty);
      chk($sformatf("t3_ovf_%0d", j), bus.overflow, vt[j].ovf);
    end
    chk("t3_no_loads", lq.size() - b, 0);
    // 4: zero-step segment skipped
    do_reset();
    busy_len = 3; bus.enable = 1;
    b = lq.size(); t0 = ncyc;
    push_seg(5, 0); push_seg(7, 2);
    wait_loads("t4_nloads", b + 1, 20);
    if (lq.size() > b) begin
      chk("t4_dt", lq[b].dt, 7);
      chk("t4_steps", lq[b].steps, 2);
      chk("t4_latency", lq[b].t - t0, 3);
    end
    repeat (20) tick();
    chk("t4_single_load", lq.size() - b, 1);
    // 5: abort while running with queued segments
    do_reset();
    busy_len = 20; bus.enable = 1;
    b = lq.size();
    for (int j = 0; j < 5; j++) push_seg(32'((j + 1) * 10), 32'(j + 1));
    wait_loads("t5_nloads", b + 1, 10);
    tick(); tick();
    chk("t5_count_before", bus.count, 4);
    bus.abort = 1; bus.wr_en = 1; bus.wr_dt = 99; bus.wr_steps = 9;
    tick();
    bus.abort = 0; bus.wr_en = 0;
    chk("t5_count", bus.count, 0);
    chk("t5_empty", bus.empty, 1);
    chk("t5_running", bus.running, 0);
    chk("t5_underrun", bus.underrun, 0);
    chk("t5_dt_kept", bus.dt_val, 10);
    repeat (40) tick();
    chk("t5_no_more_loads", lq.size() - b, 1);
    chk("t5_underrun_late", bus.underrun, 0);
    // 6: generator never acknowledges
    do_reset();
    gen_ack = 0; bus.enable = 1;
    b = lq.size();
    push_seg(11, 1); push_seg(12, 1);
    wait_loads("t6_nloads", b + 2, 30);
    if (lq.size() >= b + 2) begin
      chk("t6_gap", lq[b+1].t - lq[b].t, ACK_TMO + 1);
      chk("t6_dt1", lq[b+1].dt, 12);
    end
    repeat (10) tick();
    chk("t6_underrun", bus.underrun, 1);
    chk("t6_running", bus.running, 0);
    push_seg(13, 1);
    wait_loads("t6_nloads3", b + 3, 30);
    repeat (10) tick();
`ifdef STEP_SEQ_UNDERRUN_CNT_EN
    chk("t6_underrun_cnt", bus.underrun_cnt, 2);
`endif
    chk("t6_count", bus.count, 0);
    // randomized rounds against an in-order queue model
    do_reset();
    gen_ack = 1; bus.enable = 1; und_exp = 0;
    for (int r = 0; r < 8; r++) begin
      busy_len = $urandom_range(1, 6);
      k = $urandom_range(1, 12);
      b = lq.size(); last_nz = 0;
      exp_q.delete();
      for (int j = 0; j < k; j++) begin
        dt = $urandom;
        st = ($urandom_range(0, 3) == 0) ? 0 : 32'($urandom_range(1, 1000));
        if (st != 0) exp_q.push_back('{dt, st, 0});
        last_nz = st != 0;
        push_seg(dt, st);
      end
      nexp = exp_q.size();
      wait_loads($sformatf("rnd%0d_nloads", r), b + nexp, 200);
      for (int j = 0; j < nexp && b + j < lq.size(); j++) begin
        chk($sformatf("rnd%0d_dt%0d", r, j), lq[b+j].dt, exp_q[j].dt);
        chk($sformatf("rnd%0d_st%0d", r, j), lq[b+j].steps, exp_q[j].steps);
      end
      repeat (12) tick();
      und_exp = und_exp | last_nz;
      chk($sformatf("rnd%0d_extra", r), lq.size() - b, nexp);
      chk($sformatf("rnd%0d_underrun", r), bus.underrun, und_exp);
      chk($sformatf("rnd%0d_count", r), bus.count, 0);
      chk($sformatf("rnd%0d_running", r), bus.running, 0);
    end
    chk("load_invariants", inv_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
